n_bit_read_fifo: RTL and testbench

N_BIT_READ_FIFO -- requirements
Module: n_bit_read_fifo

---
 rtl/n_bit_read_fifo.sv | 77 +++++++
 tb/tb_n_bit_read_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/n_bit_read_fifo.sv
// rtl/n_bit_read_fifo.sv - producer-fed FIFO read by a CPU strobe, popping on the strobe's falling edge
module n_bit_read_fifo #(
    parameter int             N     = 8,
    parameter int             DEPTH = 4,
    parameter logic [N-1:0]   V     = '0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         wrStb,
    input  logic [N-1:0] inData,
    input  logic         rdStb,
    input  logic         ovrClr,
    output logic [N-1:0] dataOut,
    output logic         ready,
    output logic         full,
    output logic         overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rdstb_q;
    logic          overrun_q, overrun_d;
    logic          pop_evt, pop_ok, push_ok, drop;

    always_comb begin
        pop_evt   = rdstb_q & ~rdStb;
        pop_ok    = pop_evt && (count_q != '0);
        // A full FIFO still has a slot when the head leaves on this same edge.
        push_ok   = wrStb && ((count_q < CW'(DEPTH)) || pop_ok);
        drop      = wrStb && !push_ok;

        rd_ptr_d  = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d  = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d   = count_q + CW'(push_ok) - CW'(pop_ok);

        overrun_d = overrun_q;
        if (ovrClr) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rdstb_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            rdstb_q   <= rdStb;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr && push_ok) begin
            mem_q[wr_ptr_q] <= inData;
        end
    end

    assign dataOut = (count_q != '0) ? mem_q[rd_ptr_q] : V;
    assign ready   = (count_q != '0);
    assign full    = (count_q == CW'(DEPTH));
    assign overrun = overrun_q;

endmodule

// File: tb/tb_n_bit_read_fifo.sv
// tb/tb_n_bit_read_fifo.sv - vector table, corner sequences and randomized queue-model check
module tb_n_bit_read_fifo;

    localparam int         DEPTH = 4;
    localparam logic [7:0] VDEF  = 8'hE7;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       wrStb = 1'b0;
    logic [7:0] inData = '0;
    logic       rdStb = 1'b0;
    logic       ovrClr = 1'b0;
    logic [7:0] dataOut;
    logic       ready, full, overrun;

    int tests = 0;
    int fails = 0;

    n_bit_read_fifo #(.N(8), .DEPTH(DEPTH), .V(VDEF)) dut (
        .clk(clk), .clr(clr), .wrStb(wrStb), .inData(inData), .rdStb(rdStb),
        .ovrClr(ovrClr), .dataOut(dataOut), .ready(ready), .full(full), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of entries, last strobe level and the sticky flag
    logic [7:0] m_q [$];
    logic       m_rdprev = 1'b0;
    logic       m_ovr = 1'b0;

    typedef struct {
        logic       clr, wr;
        logic [7:0] din;
        logic       rd, oc;
        logic       erdy, efull, eovr;
        logic [7:0] edat;
    } vec_t;
    vec_t vecs [$];

    function automatic void add(input logic c, input logic w, input logic [7:0] d, input logic r,
                                input logic o, input logic er, input logic ef, input logic eo,
                                input logic [7:0] ed);
        vec_t v;
        v.clr = c; v.wr = w; v.din = d; v.rd = r; v.oc = o;
        v.erdy = er; v.efull = ef; v.eovr = eo; v.edat = ed;
        vecs.push_back(v);
    endfunction

    task automatic step(input logic c, input logic w, input logic [7:0] d, input logic r,
                        input logic o);
        logic pop, popok, avail;
        clr = c; wrStb = w; inData = d; rdStb = r; ovrClr = o;
        if (!c) begin
            m_q.delete();
            m_rdprev = 1'b0;
            m_ovr = 1'b0;
        end else begin
            pop   = m_rdprev && !r;
            popok = pop && (m_q.size() > 0);
            avail = (m_q.size() < DEPTH) || popok;
            if (popok) void'(m_q.pop_front());
            if (w && avail) m_q.push_back(d);
            if (o) m_ovr = 1'b0;
            if (w && !avail) m_ovr = 1'b1;
            m_rdprev = r;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic er, input logic ef, input logic eo,
                       input logic [7:0] ed);
        tests++;
        if (ready !== er || full !== ef || overrun !== eo || dataOut !== ed) begin
            fails++;
            $display("FAIL %s: got rdy=%b full=%b ovr=%b data=%h, need rdy=%b full=%b ovr=%b data=%h",
                     name, ready, full, overrun, dataOut, er, ef, eo, ed);
        end
    endtask

    task automatic chk_model(input string name);
        chk(name, m_q.size() != 0, m_q.size() == DEPTH, m_ovr,
            (m_q.size() != 0) ? m_q[0] : VDEF);
    endtask

    initial begin
        // reset
        add(0,0,8'h00,0,0, 0,0,0,VDEF);
        add(1,0,8'h00,0,0, 0,0,0,VDEF);
        // single push, 3-cycle strobe, pop on release
        add(1,1,8'h5A,0,0, 1,0,0,8'h5A);
        add(1,0,8'h00,1,0, 1,0,0,8'h5A);
        add(1,0,8'h00,1,0, 1,0,0,8'h5A);
        add(1,0,8'h00,1,0, 1,0,0,8'h5A);
        add(1,0,8'h00,0,0, 0,0,0,VDEF);
        // fill and overflow
        add(1,1,8'h11,0,0, 1,0,0,8'h11);
        add(1,1,8'h22,0,0, 1,0,0,8'h11);
        add(1,1,8'h33,0,0, 1,0,0,8'h11);
        add(1,1,8'h44,0,0, 1,1,0,8'h11);
        add(1,1,8'h55,0,0, 1,1,1,8'h11);
        add(1,0,8'h00,1,0, 1,1,1,8'h11);
        add(1,0,8'h00,0,0, 1,0,1,8'h22);
        add(1,0,8'h00,1,0, 1,0,1,8'h22);
        add(1,0,8'h00,0,0, 1,0,1,8'h33);
        add(1,0,8'h00,1,0, 1,0,1,8'h33);
        add(1,0,8'h00,0,0, 1,0,1,8'h44);
        add(1,0,8'h00,1,0, 1,0,1,8'h44);
        add(1,0,8'h00,0,0, 0,0,1,VDEF);
        add(1,0,8'h00,0,1, 0,0,0,VDEF);
        // full boundary: push alongside pop
        add(1,1,8'h11,0,0, 1,0,0,8'h11);
        add(1,1,8'h22,0,0, 1,0,0,8'h11);
        add(1,1,8'h33,0,0, 1,0,0,8'h11);
        add(1,1,8'h44,0,0, 1,1,0,8'h11);
        add(1,0,8'h00,1,0, 1,1,0,8'h11);
        add(1,1,8'h66,0,0, 1,1,0,8'h22);
        add(1,0,8'h00,1,0, 1,1,0,8'h22);
        add(1,0,8'h00,0,0, 1,0,0,8'h33);
        add(1,0,8'h00,1,0, 1,0,0,8'h33);
        add(1,0,8'h00,0,0, 1,0,0,8'h44);
        add(1,0,8'h00,1,0, 1,0,0,8'h44);
        add(1,0,8'h00,0,0, 1,0,0,8'h66);
        add(1,0,8'h00,1,0, 1,0,0,8'h66);
        add(1,0,8'h00,0,0, 0,0,0,VDEF);
        // empty boundary
        add(1,0,8'h00,1,0, 0,0,0,VDEF);
        add(1,0,8'h00,0,0, 0,0,0,VDEF);
        add(1,0,8'h00,1,0, 0,0,0,VDEF);
        add(1,1,8'hA5,0,0, 1,0,0,8'hA5);
        add(1,0,8'h00,1,0, 1,0,0,8'hA5);
        add(1,0,8'h00,0,0, 0,0,0,VDEF);

        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].oc);
            chk($sformatf("vec%0d", i), vecs[i].erdy, vecs[i].efull, vecs[i].eovr, vecs[i].edat);
        end

        // drop with ovrClr in the same cycle: set wins
        for (int i = 0; i < DEPTH; i++) step(1, 1, 8'hC0 + 8'(i), 0, 0);
        step(1, 1, 8'h77, 0, 1);
        chk("ovr_set_wins", 1, 1, 1, 8'hC0);
        step(1, 0, 8'h00, 0, 1);
        chk("ovr_clear", 1, 1, 0, 8'hC0);

        // reset with three entries queued and strobe high
        step(1, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 0, 0);
        chk("pre_reset_3", 1, 0, 0, 8'hC1);
        step(1, 0, 8'h00, 1, 0);
        step(0, 1, 8'h99, 1, 1);
        chk("reset_mid_read", 0, 0, 0, VDEF);
        step(1, 0, 8'h00, 1, 0);
        chk("post_reset_hold", 0, 0, 0, VDEF);
        step(1, 0, 8'h00, 0, 0);
        chk("post_reset_no_underflow", 0, 0, 0, VDEF);
        step(1, 1, 8'h3C, 0, 0);
        step(1, 1, 8'h3D, 0, 0);
        chk("post_reset_two", 1, 0, 0, 8'h3C);
        step(1, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 0, 0);
        chk("post_reset_drain", 0, 0, 0, VDEF);

        // wrap-around over ten push/read pairs
        step(0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 8'(i), 0, 0);
            chk($sformatf("wrap_push%0d", i), 1, 0, 0, 8'(i));
            step(1, 0, 8'h00, 1, 0);
            step(1, 0, 8'h00, 0, 0);
            chk($sformatf("wrap_pop%0d", i), 0, 0, 0, VDEF);
        end

        // randomized traffic against the queue model
        step(0, 0, 8'h00, 0, 0);
        chk_model("rand_reset");
        for (int i = 0; i < 600; i++) begin
            logic rn;
            rn = ($urandom_range(0, 9) < 4) ? ~rdStb : rdStb;
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                 8'($urandom),
                 rn,
                 ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0);
            chk_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
